// File: rtl/hist2d_accum_ctrl.sv
// hist2d_accum_ctrl
// 2D I/Q histogram controller. It accumulates per-shot bin coordinates into a
// 2^(2*COORD_W)-entry count RAM using a two-stage read-modify-write pipeline.
// On dump_req it streams every bin in address order ({i,q}, I-major) over a
// valid/ready link and zeroes each bin as it is read.
// Optional build macro: HIST2D_DROP_OOR_EN. When it is defined, pairs with an
// all-ones coordinate are accepted and counted in drop_count, but not stored.
// Ports:
//   clk100, rst_n (async, active-low)
//   bin_valid/bin_ready, i_bin_coord, q_bin_coord : sample input
//   dump_req, clear_req                           : control pulses
//   out_valid/out_ready, out_i_coord, out_q_coord,
//   out_count, out_last                           : dump stream
//   busy, sat_flag, drop_count                    : status
`timescale 1ns/1ps
module hist2d_accum_ctrl #(
  parameter int unsigned COORD_W = 6,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk100,
  input  logic               rst_n,
  input  logic               bin_valid,
  input  logic [COORD_W-1:0] i_bin_coord,
  input  logic [COORD_W-1:0] q_bin_coord,
  output logic               bin_ready,
  input  logic               dump_req,
  input  logic               clear_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_i_coord,
  output logic [COORD_W-1:0] out_q_coord,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_last,
  output logic               busy,
  output logic               sat_flag,
  output logic [15:0]        drop_count
);

  localparam int unsigned ADDR_W = 2 * COORD_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, DUMP} state_t;
  state_t state, state_nx;

  logic [COUNT_W-1:0] mem [DEPTH];
  logic [COUNT_W-1:0] rd_data;
  logic               we, re;
  logic [ADDR_W-1:0]  waddr, raddr;
  logic [COUNT_W-1:0] wdata;

  logic [ADDR_W-1:0]  in_addr;
  logic               accept, oor, store, drop_inc;
  logic               s1_valid, s1_fwd;
  logic [ADDR_W-1:0]  s1_addr;
  logic [COUNT_W-1:0] s1_fwd_val, s1_base, s1_new;

  logic [ADDR_W-1:0]  clr_addr, dump_addr;
  logic               dump_done, issue, last_hs;

  assign bin_ready = (state == ACCUM);
  assign busy      = (state != ACCUM);
  assign in_addr   = {i_bin_coord, q_bin_coord};
  assign accept    = bin_valid && bin_ready;

`ifdef HIST2D_DROP_OOR_EN
  assign oor = (&i_bin_coord) || (&q_bin_coord);
`else
  assign oor = 1'b0;
`endif

  assign store    = accept && !oor;
  assign drop_inc = (bin_valid && !bin_ready) || (accept && oor);

  // The RAM read issued in stage 0 cannot see the write stage 1 performs in
  // the same cycle, so a same-address hit takes stage 1's result instead.
  assign s1_base = s1_fwd ? s1_fwd_val : rd_data;
  assign s1_new  = (&s1_base) ? s1_base : s1_base + COUNT_W'(1);

  assign issue   = (state == DUMP) && !dump_done && (!out_valid || out_ready) && !clear_req;
  assign last_hs = out_valid && out_ready && out_last;

  // rd_data only reloads on a new dump read, so it holds through a stall.
  assign out_count = out_valid ? rd_data : '0;

  assign re    = issue || store;
  assign raddr = (state == DUMP) ? dump_addr : in_addr;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    unique case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_addr;
      end
      ACCUM, DRAIN: begin
        if (s1_valid) begin
          we    = 1'b1;
          waddr = s1_addr;
          wdata = s1_new;
        end
      end
      DUMP: begin
        if (issue) begin
          we    = 1'b1;
          waddr = dump_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_data <= mem[raddr];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (clr_addr == '1) state_nx = ACCUM;
      ACCUM: if (dump_req) state_nx = DRAIN;
      DRAIN: if (!s1_valid) state_nx = DUMP;
      DUMP:  if (last_hs) state_nx = ACCUM;
      default: state_nx = CLEAR;
    endcase
    if (clear_req) state_nx = CLEAR;
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR;
      s1_valid    <= 1'b0;
      s1_addr     <= '0;
      s1_fwd      <= 1'b0;
      s1_fwd_val  <= '0;
      clr_addr    <= '0;
      dump_addr   <= '0;
      dump_done   <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_i_coord <= '0;
      out_q_coord <= '0;
      sat_flag    <= 1'b0;
      drop_count  <= '0;
    end else begin
      state <= state_nx;

      // A sample accepted alongside clear_req is discarded; the sweep wipes it anyway.
      s1_valid   <= store && !clear_req;
      s1_addr    <= in_addr;
      s1_fwd     <= s1_valid && (s1_addr == in_addr);
      s1_fwd_val <= s1_new;

      if (state_nx == CLEAR && (state != CLEAR || clear_req)) clr_addr <= '0;
      else if (state == CLEAR) clr_addr <= clr_addr + ADDR_W'(1);

      if (state == DRAIN) begin
        dump_addr <= '0;
        dump_done <= 1'b0;
      end else if (issue) begin
        dump_addr <= dump_addr + ADDR_W'(1);
        if (dump_addr == '1) dump_done <= 1'b1;
      end

      if (clear_req) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (issue) begin
        out_valid   <= 1'b1;
        out_i_coord <= dump_addr[ADDR_W-1 -: COORD_W];
        out_q_coord <= dump_addr[COORD_W-1:0];
        out_last    <= (dump_addr == '1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (state == CLEAR || last_hs) sat_flag <= 1'b0;
      else if (s1_valid && (&s1_new)) sat_flag <= 1'b1;

      if (drop_inc && !(&drop_count)) drop_count <= drop_count + 16'd1;
    end
  end

endmodule
